// File: rtl/ym_timer_ctrl.sv
// YM2610 timer register front end: decodes Z80 writes to regs 0x24-0x27, drives timer A/B
// load/stop/flag-clear controls, the TICK_144 prescaler strobe, STATUS and nIRQ.
module ym_timer_ctrl #(
    parameter int unsigned TICK_DIV    = 144,
    parameter int unsigned BUSY_CYCLES = 32
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] ADDR,
    input  logic [7:0] DIN,
    input  logic       WR,
    output logic       TICK_144,
    output logic [9:0] TA_VALUE,
    output logic [7:0] TB_VALUE,
    output logic       TA_LOAD,
    output logic       TB_LOAD,
    output logic       TA_CLR_RUN,
    output logic       TB_CLR_RUN,
    output logic       TA_CLR_FLAG,
    output logic       TB_CLR_FLAG,
    input  logic       TA_OVF_FLAG,
    input  logic       TB_OVF_FLAG,
    output logic [7:0] STATUS,
    output logic       nIRQ
);

    localparam int unsigned CntW  = $clog2(TICK_DIV);
    localparam int unsigned BusyW = $clog2(BUSY_CYCLES + 1);
    localparam logic [CntW-1:0]  CntMax  = CntW'(TICK_DIV - 1);
    localparam logic [BusyW-1:0] BusyLen = BusyW'(BUSY_CYCLES);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [BusyW-1:0] busy_q, busy_d;
    logic [7:0]       addr_q, addr_d;
    logic [9:0]       ta_val_q, ta_val_d;
    logic [7:0]       tb_val_q, tb_val_d;
    logic             start_a_q, start_a_d, start_b_q, start_b_d;
    logic             ena_q, ena_d, enb_q, enb_d;
    logic             load_a_q, load_a_d, load_b_q, load_b_d;
    logic             clr_run_a_q, clr_run_a_d, clr_run_b_q, clr_run_b_d;
    logic             clr_flag_a_q, clr_flag_a_d, clr_flag_b_q, clr_flag_b_d;
    logic             nirq_q, nirq_d;

    logic tick, busy, wr_addr, wr_data;

    always_comb begin
        tick    = (cnt_q == CntMax);
        busy    = (busy_q != '0);
        wr_addr = WR & ~ADDR[1] & ~ADDR[0];
        wr_data = WR & ~ADDR[1] & ADDR[0] & ~busy;

        cnt_d        = tick ? '0 : cnt_q + 1'b1;
        busy_d       = busy ? busy_q - 1'b1 : busy_q;
        addr_d       = wr_addr ? DIN : addr_q;
        ta_val_d     = ta_val_q;
        tb_val_d     = tb_val_q;
        start_a_d    = start_a_q;
        start_b_d    = start_b_q;
        ena_d        = ena_q;
        enb_d        = enb_q;
        // A pending load is consumed by the first tick it is visible in
        load_a_d     = load_a_q & ~tick;
        load_b_d     = load_b_q & ~tick;
        clr_run_a_d  = 1'b0;
        clr_run_b_d  = 1'b0;
        clr_flag_a_d = 1'b0;
        clr_flag_b_d = 1'b0;

        if (wr_data) begin
            busy_d = BusyLen;
            case (addr_q)
                8'h24: ta_val_d[9:2] = DIN;
                8'h25: ta_val_d[1:0] = DIN[1:0];
                8'h26: tb_val_d      = DIN;
                8'h27: begin
                    start_a_d    = DIN[0];
                    start_b_d    = DIN[1];
                    ena_d        = DIN[2];
                    enb_d        = DIN[3];
                    clr_flag_a_d = DIN[4];
                    clr_flag_b_d = DIN[5];
                    if (DIN[0] && !start_a_q) load_a_d = 1'b1;
                    if (!DIN[0] && start_a_q) begin
                        load_a_d    = 1'b0;
                        clr_run_a_d = 1'b1;
                    end
                    if (DIN[1] && !start_b_q) load_b_d = 1'b1;
                    if (!DIN[1] && start_b_q) begin
                        load_b_d    = 1'b0;
                        clr_run_b_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Use next-state enables so an enable write is reflected on nIRQ the following cycle
        nirq_d = ~((TA_OVF_FLAG & ena_d) | (TB_OVF_FLAG & enb_d));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q        <= '0;
            busy_q       <= '0;
            addr_q       <= 8'h00;
            ta_val_q     <= '0;
            tb_val_q     <= '0;
            start_a_q    <= 1'b0;
            start_b_q    <= 1'b0;
            ena_q        <= 1'b0;
            enb_q        <= 1'b0;
            load_a_q     <= 1'b0;
            load_b_q     <= 1'b0;
            clr_run_a_q  <= 1'b0;
            clr_run_b_q  <= 1'b0;
            clr_flag_a_q <= 1'b0;
            clr_flag_b_q <= 1'b0;
            nirq_q       <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            addr_q       <= addr_d;
            ta_val_q     <= ta_val_d;
            tb_val_q     <= tb_val_d;
            start_a_q    <= start_a_d;
            start_b_q    <= start_b_d;
            ena_q        <= ena_d;
            enb_q        <= enb_d;
            load_a_q     <= load_a_d;
            load_b_q     <= load_b_d;
            clr_run_a_q  <= clr_run_a_d;
            clr_run_b_q  <= clr_run_b_d;
            clr_flag_a_q <= clr_flag_a_d;
            clr_flag_b_q <= clr_flag_b_d;
            nirq_q       <= nirq_d;
        end
    end

    assign TICK_144    = tick;
    assign TA_VALUE    = ta_val_q;
    assign TB_VALUE    = tb_val_q;
    assign TA_LOAD     = load_a_q;
    assign TB_LOAD     = load_b_q;
    assign TA_CLR_RUN  = clr_run_a_q;
    assign TB_CLR_RUN  = clr_run_b_q;
    assign TA_CLR_FLAG = clr_flag_a_q;
    assign TB_CLR_FLAG = clr_flag_b_q;
    assign STATUS      = {busy, 5'b00000, TB_OVF_FLAG, TA_OVF_FLAG};
    assign nIRQ        = nirq_q;

endmodule

// File: tb/tb_ym_timer_ctrl.sv
// Self-checking bench for ym_timer_ctrl: event-level reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized write phase.
module tb_ym_timer_ctrl;

    localparam int TDIV = 144;
    localparam int BLEN = 32;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [1:0] ADDR;
    logic [7:0] DIN;
    logic       WR;
    logic       TA_OVF, TB_OVF;
    logic       TICK_144, TA_LOAD, TB_LOAD, TA_CLR_RUN, TB_CLR_RUN, TA_CLR_FLAG, TB_CLR_FLAG, nIRQ;
    logic [9:0] TA_VALUE;
    logic [7:0] TB_VALUE, STATUS;

    int tests = 0;
    int fails = 0;

    ym_timer_ctrl #(.TICK_DIV(TDIV), .BUSY_CYCLES(BLEN)) dut (
        .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DIN(DIN), .WR(WR),
        .TICK_144(TICK_144), .TA_VALUE(TA_VALUE), .TB_VALUE(TB_VALUE),
        .TA_LOAD(TA_LOAD), .TB_LOAD(TB_LOAD), .TA_CLR_RUN(TA_CLR_RUN), .TB_CLR_RUN(TB_CLR_RUN),
        .TA_CLR_FLAG(TA_CLR_FLAG), .TB_CLR_FLAG(TB_CLR_FLAG),
        .TA_OVF_FLAG(TA_OVF), .TB_OVF_FLAG(TB_OVF), .STATUS(STATUS), .nIRQ(nIRQ)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle index since reset, busy time left, register contents, pending events
    int         m_cyc, m_busy_left;
    logic [7:0] m_addr, m_tb;
    logic [9:0] m_ta;
    bit m_sa, m_sb, m_ena, m_enb, m_lda, m_ldb, m_cra, m_crb, m_cfa, m_cfb, m_nirq;

    function automatic void m_reset();
        m_cyc = 0; m_busy_left = 0; m_addr = 8'h00; m_ta = '0; m_tb = '0;
        m_sa = 0; m_sb = 0; m_ena = 0; m_enb = 0; m_lda = 0; m_ldb = 0;
        m_cra = 0; m_crb = 0; m_cfa = 0; m_cfb = 0; m_nirq = 1;
    endfunction

    function automatic bit m_tick();
        return (m_cyc % TDIV) == TDIV - 1;
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_reset();
        end else begin
            bit tick_now, busy_now;
            tick_now = m_tick();
            busy_now = m_busy_left > 0;
            m_cra = 0; m_crb = 0; m_cfa = 0; m_cfb = 0;
            if (tick_now) begin m_lda = 0; m_ldb = 0; end
            if (busy_now) m_busy_left--;
            if (WR && !ADDR[1]) begin
                if (!ADDR[0]) m_addr = DIN;
                else if (!busy_now) begin
                    m_busy_left = BLEN;
                    if (m_addr == 8'h24) m_ta[9:2] = DIN;
                    if (m_addr == 8'h25) m_ta[1:0] = DIN[1:0];
                    if (m_addr == 8'h26) m_tb = DIN;
                    if (m_addr == 8'h27) begin
                        if (DIN[0] != m_sa) begin m_lda = DIN[0]; m_cra = !DIN[0]; end
                        if (DIN[1] != m_sb) begin m_ldb = DIN[1]; m_crb = !DIN[1]; end
                        m_sa = DIN[0]; m_sb = DIN[1];
                        m_ena = DIN[2]; m_enb = DIN[3];
                        m_cfa = DIN[4]; m_cfb = DIN[5];
                    end
                end
            end
            m_nirq = !((TA_OVF && m_ena) || (TB_OVF && m_enb));
            m_cyc++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        if (!RESET) begin
            chk("tick", TICK_144, m_tick());
            chk("ta_value", TA_VALUE, m_ta);
            chk("tb_value", TB_VALUE, m_tb);
            chk("ta_load", TA_LOAD, m_lda);
            chk("tb_load", TB_LOAD, m_ldb);
            chk("ta_clr_run", TA_CLR_RUN, m_cra);
            chk("tb_clr_run", TB_CLR_RUN, m_crb);
            chk("ta_clr_flag", TA_CLR_FLAG, m_cfa);
            chk("tb_clr_flag", TB_CLR_FLAG, m_cfb);
            chk("status", STATUS, {m_busy_left > 0, 5'b0, TB_OVF, TA_OVF});
            chk("nirq", nIRQ, m_nirq);
        end
    end

    int la_rise = 0;
    logic la_prev = 1'b0;
    always @(negedge CLK) begin
        if (TA_LOAD && !la_prev) la_rise++;
        la_prev = TA_LOAD;
    end

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        WR = 1'b1; ADDR = a; DIN = d;
        @(posedge CLK); #1;
        WR = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy_left != 0 && n < BLEN + 8) begin
            @(posedge CLK); #1;
            n++;
        end
        if (m_busy_left != 0) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin @(posedge CLK); #1; end
    endtask

    initial begin
        int tick_pos[$];
        int n_hi, tick_hit, busy_cnt, crun, cflag;
        RESET = 1'b1; WR = 1'b0; ADDR = 2'b00; DIN = 8'h00; TA_OVF = 1'b0; TB_OVF = 1'b0;
        cycles(3);
        #2;
        chk("rst_nirq", nIRQ, 1);
        chk("rst_status", STATUS, 8'h00);
        chk("rst_ta_load", TA_LOAD, 0);
        RESET = 1'b0;

        // Prescaler: ticks in the 144th, 288th and 432nd cycle after release
        for (int i = 0; i < 3 * TDIV; i++) begin
            @(negedge CLK);
            if (TICK_144) tick_pos.push_back(i);
        end
        chk("tick_count", tick_pos.size(), 3);
        if (tick_pos.size() == 3) begin
            chk("tick_pos0", tick_pos[0], 143);
            chk("tick_pos1", tick_pos[1], 287);
            chk("tick_pos2", tick_pos[2], 431);
        end
        @(posedge CLK); #1;

        // Timer A start
        wr(2'b00, 8'h24); wr(2'b01, 8'hFF); wait_idle();
        wr(2'b00, 8'h25); wr(2'b01, 8'h03); wait_idle();
        chk("ta_value_3ff", TA_VALUE, 10'h3FF);
        wr(2'b00, 8'h27); wr(2'b01, 8'h05);
        n_hi = 0; tick_hit = 0;
        for (int i = 0; i < TDIV + 4; i++) begin
            @(negedge CLK);
            if (TA_LOAD) begin
                n_hi++;
                if (TICK_144) tick_hit++;
            end else if (n_hi > 0) break;
        end
        chk("ta_load_one_tick", tick_hit, 1);
        chk("ta_load_dropped", TA_LOAD, 0);
        TA_OVF = 1'b1;
        #1;
        chk("status_flag_a", STATUS[0], 1);
        chk("nirq_not_yet", nIRQ, 1);
        @(posedge CLK); #1;
        chk("nirq_flag_a", nIRQ, 0);

        // Stop and flag clear
        wait_idle();
        wr(2'b01, 8'h10);
        crun = 0; cflag = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            crun += int'(TA_CLR_RUN);
            cflag += int'(TA_CLR_FLAG);
        end
        chk("ta_clr_run_pulses", crun, 1);
        chk("ta_clr_flag_pulses", cflag, 1);
        wait_idle();
        la_rise = 0;
        wr(2'b01, 8'h01); wait_idle();
        wr(2'b01, 8'h01);
        cycles(TDIV + 4);
        chk("ta_load_once", la_rise, 1);

        // Busy lockout
        wait_idle();
        wr(2'b00, 8'h26); wr(2'b01, 8'h40);
        busy_cnt = 0;
        for (int j = 0; j < 45; j++) begin
            @(negedge CLK);
            if (STATUS[7]) busy_cnt++;
            if (j == 9) begin WR = 1'b1; ADDR = 2'b00; DIN = 8'h26; end
            else if (j == 10) begin WR = 1'b1; ADDR = 2'b01; DIN = 8'h80; end
            else WR = 1'b0;
        end
        WR = 1'b0;
        chk("busy_len", busy_cnt, 32);
        chk("tb_locked", TB_VALUE, 8'h40);
        wr(2'b01, 8'h80);
        chk("tb_retry", TB_VALUE, 8'h80);

        // IRQ gating and bank ignore
        wait_idle();
        TA_OVF = 1'b0; TB_OVF = 1'b1;
        cycles(2);
        chk("nirq_gated", nIRQ, 1);
        chk("status_flag_b", STATUS[1], 1);
        wr(2'b00, 8'h27); wr(2'b01, 8'h09);
        @(negedge CLK);
        chk("nirq_enb", nIRQ, 0);
        wait_idle();
        TA_OVF = 1'b1;
        wr(2'b10, 8'h27); wr(2'b11, 8'hFF);
        cycles(3);
        chk("bank_ta", TA_VALUE, 10'h3FF);
        chk("bank_tb", TB_VALUE, 8'h80);
        chk("bank_tb_load", TB_LOAD, 0);
        chk("bank_status", STATUS, 8'h03);
        chk("bank_nirq", nIRQ, 0);

        // Randomized writes against the model
        for (int k = 0; k < 600; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            WR = 1'b0;
            if (r == 4) begin
                WR = 1'b1; ADDR = 2'b00;
                DIN = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(8'h24 + $urandom_range(0, 3));
            end else if (r >= 5 && r <= 7) begin
                WR = 1'b1; ADDR = 2'b01; DIN = 8'($urandom);
            end else if (r == 8) begin
                WR = 1'b1; ADDR = {1'b1, 1'($urandom)}; DIN = 8'($urandom);
            end else if (r == 9) begin
                TA_OVF = 1'($urandom); TB_OVF = 1'($urandom);
            end
            @(posedge CLK); #1;
        end
        WR = 1'b0;

        // Async reset while a load is pending
        wait_idle();
        TB_OVF = 1'b0; TA_OVF = 1'b1;
        wr(2'b00, 8'h24); wr(2'b01, 8'hA5); wait_idle();
        wr(2'b00, 8'h27); wr(2'b01, 8'h00); wait_idle();
        wr(2'b01, 8'h05);
        chk("pre_rst_load", TA_LOAD, 1);
        chk("pre_rst_busy", STATUS[7], 1);
        chk("pre_rst_nirq", nIRQ, 0);
        #2 RESET = 1'b1;
        #1;
        chk("arst_ta_load", TA_LOAD, 0);
        chk("arst_busy", STATUS[7], 0);
        chk("arst_ta_value", TA_VALUE, 0);
        chk("arst_nirq", nIRQ, 1);
        cycles(2);
        #2 RESET = 1'b0;
        cycles(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
